// File: rtl/mul_digit_seq_pkg.sv
// Shared types, widths and adder-cell helpers for the digit-serial multiplier.
package mul_digit_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned PP_W    = 8;

  // Returns {carry, sum}
  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  function automatic logic [1:0] fa(input logic x, input logic y, input logic cin);
    return {(x & y) | (x & cin) | (y & cin), x ^ y ^ cin};
  endfunction

endpackage

// File: rtl/mul_digit_seq_array.sv
// Purely combinational 4x4 unsigned array multiplier built from half/full-adder cells.
module mul4x4_array
  import mul_digit_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic [PP_W-1:0]    p
);

  logic carry;

  // Row r folds a*b[r] into bits r..r+3 of the running sum; its carry-out lands in bit r+4.
  always_comb begin
    p     = '0;
    carry = 1'b0;
    for (int unsigned c = 0; c < DIGIT_W; c++) begin
      p[c] = a[c] & b[0];
    end
    for (int unsigned r = 1; r < DIGIT_W; r++) begin
      {carry, p[r]} = ha(p[r], a[0] & b[r]);
      for (int unsigned c = 1; c < DIGIT_W; c++) begin
        {carry, p[r+c]} = fa(p[r+c], a[c] & b[r], carry);
      end
      p[r+DIGIT_W] = carry;
    end
  end

endmodule

// File: rtl/mul_digit_seq.sv
// Multi-cycle (4*DIGITS)x(4*DIGITS) unsigned multiplier time-sharing one 4x4 array.
// Optional: define MUL_DIGIT_SEQ_ZERO_SKIP_EN to send zero operands straight to DONE.
module mul_digit_seq
  import mul_digit_seq_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*DIGITS-1:0]     a,
  input  logic [4*DIGITS-1:0]     b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*DIGITS-1:0]     product,
  output logic                    busy
);

  localparam int unsigned W     = DIGIT_W * DIGITS;
  localparam int unsigned PW    = 2 * W;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  state_e             state, state_next;
  logic [W-1:0]       a_q, b_q;
  logic [IDX_W-1:0]   i_q, j_q;
  logic [PW-1:0]      acc_q, acc_sum;
  logic [DIGIT_W-1:0] da, db;
  logic [PP_W-1:0]    pp;
  logic               accept, last_pair, zero_op;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign accept    = in_valid && in_ready && !clear;
  assign last_pair = (i_q == LAST) && (j_q == LAST);

`ifdef MUL_DIGIT_SEQ_ZERO_SKIP_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_comb begin
    da = '0;
    db = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (i_q == IDX_W'(k)) da = a_q[k*DIGIT_W +: DIGIT_W];
      if (j_q == IDX_W'(k)) db = b_q[k*DIGIT_W +: DIGIT_W];
    end
  end

  mul4x4_array u_mul (
    .a (da),
    .b (db),
    .p (pp)
  );

  assign acc_sum = acc_q + (PW'(pp) << (DIGIT_W * (32'(i_q) + 32'(j_q))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept)    state_next = zero_op ? DONE : BUSY;
        BUSY:    if (last_pair) state_next = DONE;
        DONE:    if (out_ready) state_next = IDLE;
        default:                state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      product <= '0;
    end else if (clear) begin
      i_q   <= '0;
      j_q   <= '0;
      acc_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= a;
            b_q   <= b;
            i_q   <= '0;
            j_q   <= '0;
            acc_q <= '0;
            if (zero_op) product <= '0;
          end
        end
        BUSY: begin
          acc_q <= acc_sum;
          if (j_q == LAST) begin
            j_q <= '0;
            i_q <= last_pair ? '0 : i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
          if (last_pair) product <= acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_digit_seq.sv
// Self-checking bench for mul_digit_seq (DIGITS=2) against a plain a*b reference.
module tb_mul_digit_seq;

  localparam int unsigned DIGITS = 2;
  localparam int unsigned W      = 4 * DIGITS;
  localparam int unsigned PW     = 2 * W;
  localparam int unsigned NPAIR  = DIGITS * DIGITS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          in_ready, out_valid, busy;
  logic [PW-1:0] product;

  int checks = 0;
  int failures = 0;
  logic [PW-1:0] last_prod = '0;

  always #5 clk = ~clk;

  mul_digit_seq #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    return PW'(x) * PW'(y);
  endfunction

  // Edges after the accepting edge until out_valid is visible.
  function automatic int unsigned exp_latency(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef MUL_DIGIT_SEQ_ZERO_SKIP_EN
    if (x == '0 || y == '0) return 0;
`endif
    return NPAIR;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        output int unsigned lat, output int unsigned bcnt);
    int unsigned guard = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    a = x;
    b = y;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!out_valid && lat < 50) begin
      if (busy) bcnt++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || product !== '0) begin
      failures++;
      $display("FAIL reset_values: out_valid=%b busy=%b product=%h required 0 0 0000", out_valid, busy, product);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_ff();
    int unsigned lat, bcnt;
    out_ready = 1'b1;
    run_op(8'hFF, 8'hFF, lat, bcnt);
    checks++;
    if (lat !== exp_latency(8'hFF, 8'hFF) || bcnt !== NPAIR) begin
      failures++;
      $display("FAIL ff_timing: latency=%0d busy_cycles=%0d required %0d %0d", lat, bcnt, NPAIR, NPAIR);
    end
    checks++;
    if (product !== ref_mul(8'hFF, 8'hFF)) begin
      failures++;
      $display("FAIL ff_product: got %h required %h", product, ref_mul(8'hFF, 8'hFF));
    end
    last_prod = ref_mul(8'hFF, 8'hFF);
    step();
    checks++;
    if (out_valid !== 1'b0 || product !== last_prod) begin
      failures++;
      $display("FAIL ff_after_handshake: out_valid=%b product=%h required 0 %h", out_valid, product, last_prod);
    end
  endtask

  task automatic test_stall();
    int unsigned lat, bcnt;
    int unsigned guard;
    out_ready = 1'b0;
    run_op(8'h12, 8'h34, lat, bcnt);
    checks++;
    if (out_valid !== 1'b1 || product !== 16'h03A8) begin
      failures++;
      $display("FAIL stall_product: out_valid=%b product=%h required 1 03a8", out_valid, product);
    end
    a = 8'h55;
    b = 8'h66;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== 16'h03A8) begin
        failures++;
        $display("FAIL stall_hold[%0d]: out_valid=%b in_ready=%b product=%h required 1 0 03a8",
                 k, out_valid, in_ready, product);
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stall_no_same_cycle_accept: out_valid=%b in_ready=%b busy=%b required 0 1 0",
               out_valid, in_ready, busy);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL stall_next_accept: busy=%b required 1", busy);
    end
    guard = 0;
    while (!out_valid && guard < 50) begin
      step();
      guard++;
    end
    checks++;
    if (out_valid !== 1'b1 || product !== ref_mul(8'h55, 8'h66)) begin
      failures++;
      $display("FAIL stall_second_product: out_valid=%b product=%h required 1 %h",
               out_valid, product, ref_mul(8'h55, 8'h66));
    end
    step();
  endtask

  task automatic test_zero();
    int unsigned lat, bcnt;
    out_ready = 1'b1;
    run_op(8'h00, 8'h37, lat, bcnt);
    checks++;
    if (product !== '0 || lat !== exp_latency(8'h00, 8'h37) || bcnt !== exp_latency(8'h00, 8'h37)) begin
      failures++;
      $display("FAIL zero_operand: product=%h latency=%0d busy_cycles=%0d required 0000 %0d %0d",
               product, lat, bcnt, exp_latency(8'h00, 8'h37), exp_latency(8'h00, 8'h37));
    end
    last_prod = '0;
    step();
  endtask

  task automatic test_clear();
    int unsigned lat, bcnt;
    int unsigned seen;
    out_ready = 1'b1;
    a = 8'hA5;
    b = 8'h5A;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL clear_started: busy=%b required 1", busy);
    end
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || product !== last_prod) begin
      failures++;
      $display("FAIL clear_to_idle: busy=%b out_valid=%b in_ready=%b product=%h required 0 0 1 %h",
               busy, out_valid, in_ready, product, last_prod);
    end
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) seen++;
      step();
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL clear_no_out_valid: out_valid cycles=%0d required 0", seen);
    end
    run_op(8'h03, 8'h07, lat, bcnt);
    checks++;
    if (product !== 16'h0015 || lat !== NPAIR) begin
      failures++;
      $display("FAIL clear_next_op: product=%h latency=%0d required 0015 %0d", product, lat, NPAIR);
    end
    last_prod = 16'h0015;
    step();
  endtask

  task automatic test_async_reset();
    int unsigned lat, bcnt;
    out_ready = 1'b1;
    a = 8'h12;
    b = 8'h34;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || product !== '0) begin
      failures++;
      $display("FAIL async_reset: busy=%b out_valid=%b product=%h required 0 0 0000", busy, out_valid, product);
    end
    #2 rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    run_op(8'h80, 8'h02, lat, bcnt);
    checks++;
    if (product !== 16'h0100) begin
      failures++;
      $display("FAIL async_next_op: product=%h required 0100", product);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] expq[$];
    int sent = 0;
    int recv = 0;
    int last_acc = -1;
    int cyc = 0;
    logic acc_now;
    in_valid = 1'b0;
    while (recv < 100 && cyc < 5000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
        a = W'($urandom_range(1, 255));
        b = W'($urandom_range(1, 255));
        in_valid = 1'b1;
      end
      if (out_valid) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL b2b_spurious: product=%h with no outstanding operand", product);
        end else if (product !== expq[0]) begin
          failures++;
          $display("FAIL b2b_product[%0d]: got %h required %h", recv, product, expq[0]);
        end
        if (out_ready) begin
          if (expq.size() != 0) void'(expq.pop_front());
          recv++;
        end
      end
      acc_now = in_valid && in_ready;
      if (acc_now) begin
        expq.push_back(ref_mul(a, b));
        sent++;
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc < int'(NPAIR + 2)) begin
            failures++;
            $display("FAIL b2b_interval: got %0d required >= %0d", cyc - last_acc, NPAIR + 2);
          end
        end
        last_acc = cyc;
      end
      step();
      cyc++;
      if (acc_now) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (sent != 100 || recv != 100 || expq.size() != 0) begin
      failures++;
      $display("FAIL b2b_count: sent=%0d received=%0d outstanding=%0d required 100 100 0",
               sent, recv, expq.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ff();
    test_stall();
    test_zero();
    test_clear();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
